// File: rtl/dmem_wait_responder.sv
// rtl/dmem_wait_responder.sv - MEM-stage data-memory responder with wait states
//
// Word-addressed RAM behind a valid/ready request channel. Each accepted
// request is held for WAIT_CYCLES wait states, then committed on the edge that
// enters RESP, where a one-cycle resp_valid pulse is raised. Misaligned or
// out-of-range accesses are flagged with resp_err and never touch the RAM.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   req_valid   core presents a request
//   req_write   1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data
//   req_ready   request is accepted on this cycle's edge when req_valid=1
//   resp_valid  one-cycle completion pulse
//   resp_rdata  load data (0 for stores and errors), held until next commit
//   resp_err    misaligned / out-of-range flag, held until next commit
//   stall_m     hold the core pipeline while a request is outstanding

module dmem_wait_responder #(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall_m
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ready_q;
    logic        valid_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [31:0] mem [DEPTH];

    // Commit-side view of the access. With zero wait states the commit happens
    // on the accept edge itself, so the live request inputs are used instead of
    // the latched copy.
    logic             accept;
    logic             commit_d;
    logic             commit_write_d;
    logic [31:0]      commit_addr_d;
    logic [31:0]      commit_wdata_d;
    logic [31:0]      commit_off_d;
    logic             commit_err_d;
    logic [IDX_W-1:0] commit_idx_d;
    logic             mem_we;

    always_comb begin
        accept         = req_valid && ready_q && (state_q == ST_IDLE);
        commit_d       = 1'b0;
        commit_write_d = wr_q;
        commit_addr_d  = addr_q;
        commit_wdata_d = wdata_q;
        if ((state_q == ST_IDLE) && (WAIT_CYCLES == 0) && accept) begin
            commit_d       = 1'b1;
            commit_write_d = req_write;
            commit_addr_d  = req_addr;
            commit_wdata_d = req_wdata;
        end else if ((state_q == ST_WAIT) && (cnt_q == 4'd0)) begin
            commit_d = 1'b1;
        end
        commit_off_d = commit_addr_d - BASE_ADDR;
        commit_err_d = (commit_addr_d[1:0] != 2'b00)
                    || (commit_addr_d < BASE_ADDR)
                    || ((commit_off_d >> 2) >= DEPTH_W);
        commit_idx_d = commit_off_d[IDX_W+1:2];
    end

    // A reset coinciding with the commit edge must suppress the write, since
    // the RAM itself has no reset.
    assign mem_we = commit_d && commit_write_d && !commit_err_d && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[commit_idx_d] <= commit_wdata_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        wr_q    <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Counter stops at zero; it is only reloaded on accept.
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
            if (commit_d) begin
                valid_q <= 1'b1;
                err_q   <= commit_err_d;
                rdata_q <= (commit_err_d || commit_write_d) ? 32'd0 : mem[commit_idx_d];
            end
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    // The core advances in the RESP cycle, when the response is visible.
    assign stall_m    = req_valid && !valid_q;

endmodule
